pwm_gen: RTL and testbench
==========================

Name: pwm_gen

Overview:
- Downstream consumer of the 8-bit free-running wrap counter.
- Compares the counter value against a double-buffered duty value to produce a registered PWM output and a period-boundary tick.
- New duty values arrive over a valid/ready handshake and take effect only at a period boundary, so the output never glitches.
- Detects counter discontinuities (counter reset or skip) and resynchronises to the next period.

Parameters:
- W, 8: counter and duty width; period = 2**W cycles.
- IDLE_LEVEL, 1'b0: value pwm_out drives when not in RUN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- count  input  W  counter value from the upstream counter.
- enable  input  1  request to run PWM (level).
- duty_in  input  W  new duty value.
- duty_valid  input  1  duty_in is valid.
- duty_ready  output  1  shadow register empty; can accept duty_in.
- pwm_out  output  1  registered PWM output.
- period_tick  output  1  one-cycle pulse marking the end of a period.
- active_duty  output  W  duty value currently applied.
- sync_err  output  1  one-cycle pulse on counter discontinuity.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous) values:
  - state=IDLE, pwm_out=IDLE_LEVEL, period_tick=0, sync_err=0, busy=0
  - active_duty=0, shadow empty, duty_ready=1, prev_count=0, prev_valid=0
- Boundary: wrap_pt = (count == all-ones).
- Continuity check:
  - Valid only when prev_valid=1 (set the first cycle after reset, then held).
  - Discontinuity = prev_valid && count != prev_count+1 (mod 2**W).
  - prev_count is registered every cycle.
- Handshake:
  - Transfer on duty_valid && duty_ready; duty_in is captured into shadow and shadow_full is set.
  - duty_ready = !shadow_full (combinational from the register).
  - shadow_full clears on commit.
  - A second valid while the shadow is full stalls; no overwrite.
- Commit:
  - Occurs on the cycle wrap_pt=1 in any state except IDLE: active_duty <= shadow, shadow_full <= 0.
  - In IDLE, shadow commits immediately the cycle after capture.
  - Simultaneous commit and new transfer at wrap_pt: the commit moves the old shadow value; the new value is not accepted that cycle, because ready was 0.
- States:
  - IDLE: pwm_out=IDLE_LEVEL. enable=1 -> SYNC.
  - SYNC: pwm_out=IDLE_LEVEL. wrap_pt -> RUN. enable=0 -> IDLE.
  - RUN: pwm_out <= (count < active_duty), registered, so it lags count by 1 cycle.
    - Discontinuity -> SYNC, pwm_out=IDLE_LEVEL, sync_err pulses.
    - enable=0 -> DRAIN.
  - DRAIN: keeps driving PWM as in RUN until wrap_pt, then -> IDLE. enable=1 again before wrap_pt -> RUN. A discontinuity -> IDLE with a sync_err pulse.
- Duty edge cases:
  - duty=0: pwm_out constantly 0 in RUN.
  - duty=2**W-1: high for 255 of 256 cycles (low only at count=FF).
  - Comparison is unsigned, W bits, with no extension.
- period_tick: registered; asserts the cycle after wrap_pt in RUN or DRAIN only.
- Mid-operation reset: all state returns to reset values immediately, without waiting for clk. The first post-reset cycle does no continuity check.
- busy = (state != IDLE).

Decomposition:
- Shared package pwm_pkg:
  - state enum {IDLE, SYNC, RUN, DRAIN}, 2 bits.
  - Default W.
  - all-ones constant helper.
- One natural sub-module, duty_shadow: the handshake plus shadow register with commit strobe, reusable for other double-buffered controls.
- Comparator and FSM stay in pwm_gen.

Test Plan:
- Reset, then drive upstream counter free-running from 0, enable=1, duty 0x40 loaded in IDLE:
  - active_duty=0x40 next cycle.
  - SYNC until count=FF.
  - Then each period: pwm_out high 64 cycles, low 192; period_tick every 256 cycles.
- While RUN at duty 0x40, load 0x80 mid-period:
  - duty_ready=0 until the count=FF cycle.
  - New duty applies from the next count=00; the current period stays at 64 high.
  - A second valid while full stalls.
- Duty corner cases:
  - duty=0x00 -> pwm_out never high.
  - duty=0xFF -> 255 high cycles, low only for count=FF (seen 1 cycle later).
- Upstream counter reset mid-period (count jumps 0x37->0x00):
  - sync_err pulses once.
  - State SYNC, pwm_out=0 until the next count=FF, then RUN resumes.
- enable dropped at count=0x10:
  - Output continues through count=FF, then IDLE.
  - No period_tick after that.
  - Re-asserting enable at count=0x80 during DRAIN keeps RUN with no gap.
- rst asserted low mid-RUN (asynchronously between clock edges):
  - Outputs go to reset values immediately.
  - After release, no sync_err on the first cycle.

Source files
------------

// File: rtl/pwm_pkg.sv
// ----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the PWM generator: default counter/duty width,
// controller state encoding and an all-ones mask helper.
// ----------------------------------------------------------------------------
package pwm_pkg;

   // Default counter and duty width; the PWM period is 2**PWM_W cycles.
   localparam int unsigned PWM_W = 8;

   // Controller states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SYNC  = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } pwm_state_e;

   // Mask with the low w bits set; callers cast it down to their own width.
   function automatic logic [31:0] ones_mask(input int unsigned w);
      logic [31:0] m;
      if (w >= 32) begin
         m = '1;
      end else begin
         m = (32'd1 << w) - 32'd1;
      end
      return m;
   endfunction

endpackage : pwm_pkg

// File: rtl/pwm_gen_duty_shadow.sv
// ----------------------------------------------------------------------------
// pwm_gen_duty_shadow
// Double-buffered control register: a valid/ready handshake loads a shadow
// register, and a commit strobe moves the shadow into the active register.
// A full shadow holds off further transfers, so a pending value is never
// overwritten before it has been applied.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-low reset
//   i_data    in   W   new value offered by the producer
//   i_valid   in   1   i_data is valid
//   o_ready   out  1   shadow empty; a transfer completes on i_valid & o_ready
//   i_commit  in   1   apply the shadow value this cycle (ignored when empty)
//   o_active  out  W   value currently applied
//   o_full    out  1   shadow holds a value waiting for commit
// ----------------------------------------------------------------------------
module pwm_gen_duty_shadow
   import pwm_pkg::*;
#(
   parameter int unsigned W = PWM_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] i_data,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic         i_commit,
   output logic [W-1:0] o_active,
   output logic         o_full
);

   logic [W-1:0] r_shadow;
   logic [W-1:0] r_active;
   logic         r_full;
   logic         w_xfer;
   logic         w_commit;

   // Ready only reflects the register so it never depends on i_valid.
   assign o_ready  = !r_full;
   assign w_xfer   = i_valid && !r_full;
   assign w_commit = i_commit && r_full;

   // Transfer needs an empty shadow and commit needs a full one, so the two
   // can never happen in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_shadow <= '0;
         r_active <= '0;
         r_full   <= 1'b0;
      end else if (w_commit) begin
         r_active <= r_shadow;
         r_full   <= 1'b0;
      end else if (w_xfer) begin
         r_shadow <= i_data;
         r_full   <= 1'b1;
      end
   end

   assign o_active = r_active;
   assign o_full   = r_full;

endmodule : pwm_gen_duty_shadow

// File: rtl/pwm_gen.sv
// ----------------------------------------------------------------------------
// pwm_gen
// PWM generator fed by an external free-running W-bit wrap counter. The
// counter is compared against a double-buffered duty value to produce a
// registered PWM output and an end-of-period tick. New duty values are taken
// over a valid/ready handshake and applied only at a period boundary (or at
// once while idle). Counter discontinuities drop the output and resynchronise
// to the next period.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-low reset
//   count        in   W   upstream counter value
//   enable       in   1   run request (level)
//   duty_in      in   W   new duty value
//   duty_valid   in   1   duty_in is valid
//   duty_ready   out  1   shadow empty; duty_in can be accepted
//   pwm_out      out  1   registered PWM output (lags count by one cycle)
//   period_tick  out  1   one-cycle pulse after the last count of a period
//   active_duty  out  W   duty value currently applied
//   sync_err     out  1   one-cycle pulse on a counter discontinuity
//   busy         out  1   controller is not idle
// ----------------------------------------------------------------------------
module pwm_gen
   import pwm_pkg::*;
#(
   parameter int unsigned W          = PWM_W,
   parameter logic        IDLE_LEVEL = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] count,
   input  logic         enable,
   input  logic [W-1:0] duty_in,
   input  logic         duty_valid,
   output logic         duty_ready,
   output logic         pwm_out,
   output logic         period_tick,
   output logic [W-1:0] active_duty,
   output logic         sync_err,
   output logic         busy
);

   localparam logic [W-1:0] CNT_MAX = W'(ones_mask(W));

   pwm_state_e   r_state;
   pwm_state_e   w_state_nxt;

   logic [W-1:0] r_prev_count;
   logic         r_prev_valid;
   logic [W-1:0] w_count_exp;
   logic         w_wrap;
   logic         w_disc;
   logic         w_running;

   logic         w_commit;
   logic         w_shadow_full;
   logic [W-1:0] w_active;

   logic         w_pwm_nxt;
   logic         w_tick_nxt;
   logic         w_err_nxt;
   logic         r_pwm;
   logic         r_tick;
   logic         r_err;

   // Period boundary and continuity check against the previous sample.
   assign w_wrap      = (count == CNT_MAX);
   assign w_count_exp = r_prev_count + W'(1);
   assign w_disc      = r_prev_valid && (count != w_count_exp);
   assign w_running   = (r_state == ST_RUN) || (r_state == ST_DRAIN);

   // Previous-count history; prev_valid stays low for the first cycle after
   // reset so no continuity check is made against the reset value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_prev_count <= '0;
         r_prev_valid <= 1'b0;
      end else begin
         r_prev_count <= count;
         r_prev_valid <= 1'b1;
      end
   end

   // Idle applies a pending duty straight away; otherwise only at the wrap.
   assign w_commit = (r_state == ST_IDLE) ? w_shadow_full : w_wrap;

   pwm_gen_duty_shadow #(
      .W (W)
   ) u_duty_shadow (
      .clk      (clk),
      .rst      (rst),
      .i_data   (duty_in),
      .i_valid  (duty_valid),
      .o_ready  (duty_ready),
      .i_commit (w_commit),
      .o_active (w_active),
      .o_full   (w_shadow_full)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic. A discontinuity outranks enable changes.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (enable) begin
               w_state_nxt = ST_SYNC;
            end
         end
         ST_SYNC: begin
            if (!enable) begin
               w_state_nxt = ST_IDLE;
            end else if (w_wrap) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_disc) begin
               w_state_nxt = ST_SYNC;
            end else if (!enable) begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (w_disc) begin
               w_state_nxt = ST_IDLE;
            end else if (enable) begin
               w_state_nxt = ST_RUN;
            end else if (w_wrap) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Output decode: next values of the registered outputs. DRAIN keeps
   // modulating exactly like RUN until the period finishes.
   always_comb begin
      w_pwm_nxt  = IDLE_LEVEL;
      w_tick_nxt = 1'b0;
      w_err_nxt  = 1'b0;
      if (w_running) begin
         w_tick_nxt = w_wrap;
         w_err_nxt  = w_disc;
         if (!w_disc) begin
            w_pwm_nxt = (count < w_active);
         end
      end
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pwm  <= IDLE_LEVEL;
         r_tick <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_pwm  <= w_pwm_nxt;
         r_tick <= w_tick_nxt;
         r_err  <= w_err_nxt;
      end
   end

   assign pwm_out     = r_pwm;
   assign period_tick = r_tick;
   assign sync_err    = r_err;
   assign active_duty = w_active;
   assign busy        = (r_state != ST_IDLE);

endmodule : pwm_gen

// File: tb/tb_pwm_gen.sv
// ----------------------------------------------------------------------------
// tb_pwm_gen
// Self-checking bench for pwm_gen. A reference model predicts each cycle's
// outputs into a scoreboard queue; a table of duty values with hand-derived
// high/tick counts per period, plus hand-written corner-case sequences.
// ----------------------------------------------------------------------------
module tb_pwm_gen;

   localparam int unsigned W = 8;

   localparam int M_IDLE  = 0;
   localparam int M_SYNC  = 1;
   localparam int M_RUN   = 2;
   localparam int M_DRAIN = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] count;
   logic         enable;
   logic [W-1:0] duty_in;
   logic         duty_valid;
   logic         duty_ready;
   logic         pwm_out;
   logic         period_tick;
   logic [W-1:0] active_duty;
   logic         sync_err;
   logic         busy;

   always #5 clk = ~clk;

   pwm_gen #(
      .W          (W),
      .IDLE_LEVEL (1'b0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .count       (count),
      .enable      (enable),
      .duty_in     (duty_in),
      .duty_valid  (duty_valid),
      .duty_ready  (duty_ready),
      .pwm_out     (pwm_out),
      .period_tick (period_tick),
      .active_duty (active_duty),
      .sync_err    (sync_err),
      .busy        (busy)
   );

   typedef struct {
      logic         pwm;
      logic         tick;
      logic         err;
      logic         busy;
      logic [W-1:0] duty;
   } exp_t;

   typedef struct {
      logic [W-1:0] duty;
      int unsigned  high;
      int unsigned  ticks;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[6];

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model state
   logic [W-1:0] cnt;
   int           m_mode;
   logic [W-1:0] m_duty;
   logic [W-1:0] m_shadow;
   logic         m_full;
   logic [W-1:0] m_prev;
   logic         m_pv;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) begin
         n_pass++;
      end else begin
         $display("FAIL %s: actual %0h required %0h at t=%0t", nm, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_mode   = M_IDLE;
      m_duty   = '0;
      m_shadow = '0;
      m_full   = 1'b0;
      m_prev   = '0;
      m_pv     = 1'b0;
      sb.delete();
   endtask

   // Drive one counter value for one clock, predict, then compare.
   task automatic step();
      exp_t e;
      logic w, disc, run, commit, accept;
      int   nxt;
      count  = cnt;
      w      = (cnt == 8'hFF);
      disc   = m_pv && (cnt != 8'(m_prev + 8'd1));
      run    = (m_mode == M_RUN) || (m_mode == M_DRAIN);
      chk("duty_ready", 32'(duty_ready), 32'(!m_full));
      commit = m_full && ((m_mode == M_IDLE) || w);
      accept = duty_valid && !m_full;
      nxt    = m_mode;
      case (m_mode)
         M_IDLE:  if (enable) nxt = M_SYNC;
         M_SYNC:  if (!enable) nxt = M_IDLE; else if (w) nxt = M_RUN;
         M_RUN:   if (disc) nxt = M_SYNC; else if (!enable) nxt = M_DRAIN;
         default: if (disc) nxt = M_IDLE; else if (enable) nxt = M_RUN;
                  else if (w) nxt = M_IDLE;
      endcase
      e.pwm  = (run && !disc) ? (cnt < m_duty) : 1'b0;
      e.tick = run && w;
      e.err  = run && disc;
      if (commit) begin
         m_duty = m_shadow;
         m_full = 1'b0;
      end
      if (accept) begin
         m_shadow = duty_in;
         m_full   = 1'b1;
      end
      m_prev = cnt;
      m_pv   = 1'b1;
      m_mode = nxt;
      e.busy = (nxt != M_IDLE);
      e.duty = m_duty;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("pwm_out",     32'(pwm_out),     32'(e.pwm));
      chk("period_tick", 32'(period_tick), 32'(e.tick));
      chk("sync_err",    32'(sync_err),    32'(e.err));
      chk("busy",        32'(busy),        32'(e.busy));
      chk("active_duty", 32'(active_duty), 32'(e.duty));
      cnt = cnt + 8'd1;
   endtask

   task automatic run_to(input logic [W-1:0] t);
      for (int i = 0; i < 300 && cnt != t; i++) step();
      chk("run_to_reach", 32'(cnt), 32'(t));
   endtask

   task automatic measure(input string nm, input int unsigned eh, input int unsigned et);
      int unsigned h = 0;
      int unsigned t = 0;
      for (int k = 0; k < 256; k++) begin
         step();
         h += 32'(pwm_out);
         t += 32'(period_tick);
      end
      chk({nm, "_high"},  h, eh);
      chk({nm, "_ticks"}, t, et);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned errs;
      vecs[0] = '{8'h40,  64, 1};
      vecs[1] = '{8'h80, 128, 1};
      vecs[2] = '{8'h00,   0, 1};
      vecs[3] = '{8'hFF, 255, 1};
      vecs[4] = '{8'h01,   1, 1};
      vecs[5] = '{8'h40,  64, 1};

      // Reset values
      rst = 1'b0; enable = 1'b0; duty_valid = 1'b0; duty_in = '0; count = '0;
      cnt = '0;
      model_reset();
      #12;
      chk("rst_pwm",    32'(pwm_out),     32'd0);
      chk("rst_tick",   32'(period_tick), 32'd0);
      chk("rst_err",    32'(sync_err),    32'd0);
      chk("rst_busy",   32'(busy),        32'd0);
      chk("rst_active", 32'(active_duty), 32'd0);
      chk("rst_ready",  32'(duty_ready),  32'd1);
      @(negedge clk);
      rst = 1'b1;

      // Duty 0x40 loaded while idle commits the cycle after capture
      duty_in = 8'h40; duty_valid = 1'b1;
      step();
      duty_valid = 1'b0;
      chk("idle_capture_ready", 32'(duty_ready), 32'd0);
      step();
      chk("idle_commit", 32'(active_duty), 32'h40);
      chk("idle_ready_back", 32'(duty_ready), 32'd1);

      // Enable: SYNC until count=FF, then RUN
      enable = 1'b1;
      step();
      chk("sync_busy", 32'(busy), 32'd1);
      run_to(8'hFF);
      chk("sync_pwm_low", 32'(pwm_out), 32'd0);
      step();

      // Table: mid-period load, stalled second valid, one measured period
      for (int v = 0; v < 6; v++) begin
         run_to(8'h20);
         duty_in = vecs[v].duty; duty_valid = 1'b1;
         step();
         chk("load_ready_low", 32'(duty_ready), 32'd0);
         duty_in = ~vecs[v].duty;
         for (int k = 0; k < 4; k++) step();
         duty_valid = 1'b0;
         run_to(8'hFF);
         chk("ready_low_at_ff", 32'(duty_ready), 32'd0);
         step();
         chk("ready_after_commit", 32'(duty_ready), 32'd1);
         chk("vec_active", 32'(active_duty), 32'(vecs[v].duty));
         measure("vec", vecs[v].high, vecs[v].ticks);
      end

      // Counter reset mid-period: 0x37 -> 0x00
      run_to(8'h37);
      step();
      cnt = 8'h00;
      step();
      chk("disc_err", 32'(sync_err), 32'd1);
      chk("disc_busy", 32'(busy), 32'd1);
      errs = 0;
      for (int i = 0; i < 300 && cnt != 8'hFF; i++) begin
         step();
         errs += 32'(sync_err);
         chk("disc_sync_low", 32'(pwm_out), 32'd0);
      end
      chk("disc_err_once", errs, 32'd0);
      step();
      step();
      chk("disc_run_resume", 32'(pwm_out), 32'd1);

      // Enable drop at 0x10, re-asserted at 0x80 during DRAIN
      run_to(8'h10);
      enable = 1'b0;
      step();
      run_to(8'h80);
      enable = 1'b1;
      step();
      chk("redrain_busy", 32'(busy), 32'd1);
      run_to(8'h00);
      measure("reenable", 64, 1);

      // Enable drop at 0x10 without re-enable: finish period, then idle
      run_to(8'h10);
      enable = 1'b0;
      step();
      run_to(8'hFF);
      step();
      chk("drain_tick", 32'(period_tick), 32'd1);
      chk("drain_idle", 32'(busy), 32'd0);
      measure("idle", 0, 0);

      // Asynchronous reset mid-RUN
      enable = 1'b1;
      run_to(8'hFF);
      step();
      run_to(8'h20);
      step();
      chk("pre_rst_pwm", 32'(pwm_out), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_pwm",    32'(pwm_out),     32'd0);
      chk("arst_busy",   32'(busy),        32'd0);
      chk("arst_active", 32'(active_duty), 32'd0);
      chk("arst_ready",  32'(duty_ready),  32'd1);
      chk("arst_err",    32'(sync_err),    32'd0);
      model_reset();
      #8;
      @(negedge clk);
      rst = 1'b1;
      cnt = 8'h99;
      step();
      chk("post_rst_err", 32'(sync_err), 32'd0);
      for (int i = 0; i < 4; i++) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_pwm_gen
